// File: rtl/fir_sched_pkg.sv
// ---------------------------------------------------------------------------
// fir_sched_pkg
// Shared types and helpers for the FIR stage scheduler.
//   state_t    : scheduler FSM states (IDLE, ISSUE, WAIT)
//   stage_w()  : index width for a count of n items, never narrower than 1 bit
//   MAX_STAGES : largest supported decimation cascade depth
// ---------------------------------------------------------------------------
package fir_sched_pkg;

   localparam int MAX_STAGES = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Width needed to index n items; a single item still gets one bit.
   function automatic int stage_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_stage_scheduler.sv
// ---------------------------------------------------------------------------
// fir_stage_scheduler
// Time-shares one external FIR engine across a cascade of NUM_STAGES
// decimate-by-DEC_FACTOR stages. Stage 0 takes audio samples, each later
// stage takes every DEC_FACTOR-th result of the stage before it, and the last
// stage drives dec_output.
//
// Ports
//   clk_in             : system clock
//   rst_in             : asynchronous, active-high reset
//   audio_in           : signed input sample
//   audio_sample_valid : 1-cycle strobe, audio_in valid
//   eng_start          : 1-cycle pulse, engine begins on eng_stage/eng_sample
//   eng_stage          : stage index (delay line / coefficient select)
//   eng_sample         : sample presented to the engine
//   eng_done           : 1-cycle strobe, eng_result valid
//   eng_result         : filtered sample from the engine
//   dec_output         : final decimated sample (held)
//   dec_output_ready   : 1-cycle strobe, dec_output updated
//   overrun            : sticky, a sample was dropped
//   timeout_err        : sticky, engine watchdog fired
//
// Build option
//   FIR_SCHED_TIMEOUT_EN : adds a WAIT-state watchdog of TIMEOUT cycles.
//                          Without it WAIT waits forever and timeout_err is 0.
// ---------------------------------------------------------------------------
module fir_stage_scheduler
   import fir_sched_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int NUM_STAGES = 2,
   parameter int DEC_FACTOR = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic [WIDTH-1:0]                audio_in,
   input  logic                            audio_sample_valid,
   output logic                            eng_start,
   output logic [stage_w(NUM_STAGES)-1:0]  eng_stage,
   output logic [WIDTH-1:0]                eng_sample,
   input  logic                            eng_done,
   input  logic [WIDTH-1:0]                eng_result,
   output logic [WIDTH-1:0]                dec_output,
   output logic                            dec_output_ready,
   output logic                            overrun,
   output logic                            timeout_err
);

   localparam int SW = stage_w(NUM_STAGES);
   localparam int CW = stage_w(DEC_FACTOR);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEC_FACTOR - 1);
   localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

   state_t                  state_q, state_d;
   logic [NUM_STAGES-1:0]   pending_q, pending_d;
   logic [WIDTH-1:0]        slot_q [NUM_STAGES];
   logic [WIDTH-1:0]        slot_d [NUM_STAGES];
   logic [CW-1:0]           cnt_q  [NUM_STAGES];
   logic [CW-1:0]           cnt_d  [NUM_STAGES];

   logic                    eng_start_q, eng_start_d;
   logic [SW-1:0]           eng_stage_q, eng_stage_d;
   logic [WIDTH-1:0]        eng_sample_q, eng_sample_d;
   logic [WIDTH-1:0]        dec_output_q, dec_output_d;
   logic                    dec_output_ready_q, dec_output_ready_d;
   logic                    overrun_q, overrun_d;

   logic [SW-1:0]           pick;
   logic                    any_pending;
   logic [SW-1:0]           next_stage;

`ifdef FIR_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   logic [WD_W-1:0]         wd_q, wd_d;
   logic                    timeout_err_q, timeout_err_d;
`endif

   // Stage currently owning the engine forwards into the one after it.
   assign next_stage = eng_stage_q + SW'(1);

   // Priority pick: the loop runs upward so the highest pending index wins,
   // which drains deep stages before feeding them more work.
   always_comb begin
      pick        = '0;
      any_pending = |pending_q;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (pending_q[i]) begin
            pick = SW'(i);
         end
      end
   end

   // Next-state logic for the FSM, the per-stage bookkeeping and every
   // registered output. The input-accept block sits after the FSM case so
   // that a new stage-0 sample overrides the ISSUE-cycle pending clear.
   always_comb begin
      state_d            = state_q;
      pending_d          = pending_q;
      slot_d             = slot_q;
      cnt_d              = cnt_q;
      eng_start_d        = 1'b0;
      eng_stage_d        = eng_stage_q;
      eng_sample_d       = eng_sample_q;
      dec_output_d       = dec_output_q;
      dec_output_ready_d = 1'b0;
      overrun_d          = overrun_q;
`ifdef FIR_SCHED_TIMEOUT_EN
      wd_d               = wd_q;
      timeout_err_d      = timeout_err_q;
`endif

      case (state_q)
         IDLE: begin
            if (any_pending) begin
               state_d      = ISSUE;
               eng_start_d  = 1'b1;
               eng_stage_d  = pick;
               eng_sample_d = slot_q[pick];
            end
         end

         ISSUE: begin
            pending_d[eng_stage_q] = 1'b0;
            state_d                = WAIT;
`ifdef FIR_SCHED_TIMEOUT_EN
            wd_d                   = '0;
`endif
         end

         WAIT: begin
            if (eng_done) begin
               state_d = IDLE;
               if (cnt_q[eng_stage_q] == CNT_LAST) begin
                  cnt_d[eng_stage_q] = '0;
                  if (eng_stage_q == LAST_STAGE) begin
                     dec_output_d       = eng_result;
                     dec_output_ready_d = 1'b1;
                  end else if (pending_q[next_stage]) begin
                     // Downstream slot still unissued: keep its old sample.
                     overrun_d = 1'b1;
                  end else begin
                     slot_d[next_stage]    = eng_result;
                     pending_d[next_stage] = 1'b1;
                  end
               end else begin
                  cnt_d[eng_stage_q] = cnt_q[eng_stage_q] + CW'(1);
               end
            end
`ifdef FIR_SCHED_TIMEOUT_EN
            // Abandon the job; the stage counter is left untouched.
            else if (wd_q == WD_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
`endif
         end

         default: state_d = IDLE;
      endcase

      // Stage 0 may be refilled in the same cycle it is being issued.
      if (audio_sample_valid) begin
         if (pending_q[0] && !(state_q == ISSUE && eng_stage_q == '0)) begin
            overrun_d = 1'b1;
         end else begin
            slot_d[0]    = audio_in;
            pending_d[0] = 1'b1;
         end
      end
   end

   // All state lives here; reset clears everything immediately.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q            <= IDLE;
         pending_q          <= '0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            slot_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         eng_start_q        <= 1'b0;
         eng_stage_q        <= '0;
         eng_sample_q       <= '0;
         dec_output_q       <= '0;
         dec_output_ready_q <= 1'b0;
         overrun_q          <= 1'b0;
`ifdef FIR_SCHED_TIMEOUT_EN
         wd_q               <= '0;
         timeout_err_q      <= 1'b0;
`endif
      end else begin
         state_q            <= state_d;
         pending_q          <= pending_d;
         for (int i = 0; i < NUM_STAGES; i++) begin
            slot_q[i] <= slot_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         eng_start_q        <= eng_start_d;
         eng_stage_q        <= eng_stage_d;
         eng_sample_q       <= eng_sample_d;
         dec_output_q       <= dec_output_d;
         dec_output_ready_q <= dec_output_ready_d;
         overrun_q          <= overrun_d;
`ifdef FIR_SCHED_TIMEOUT_EN
         wd_q               <= wd_d;
         timeout_err_q      <= timeout_err_d;
`endif
      end
   end

   assign eng_start        = eng_start_q;
   assign eng_stage        = eng_stage_q;
   assign eng_sample       = eng_sample_q;
   assign dec_output       = dec_output_q;
   assign dec_output_ready = dec_output_ready_q;
   assign overrun          = overrun_q;

`ifdef FIR_SCHED_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`else
   // No watchdog in this build; the flag can never rise.
   assign timeout_err = 1'b0 & (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_fir_stage_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fir_stage_scheduler
// Self-checking bench for fir_stage_scheduler (WIDTH=8, NUM_STAGES=2,
// DEC_FACTOR=4, TIMEOUT=8). A behavioural engine returns sample+1 after a
// configurable latency. A reference model predicts, per input sample, the
// ordered list of engine issues and final decimated outputs from the
// cascade rules alone; a monitor compares every eng_start and
// dec_output_ready against those predictions.
// Build option FIR_SCHED_TIMEOUT_EN enables the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_fir_stage_scheduler;
   import fir_sched_pkg::*;

   localparam int WIDTH      = 8;
   localparam int NUM_STAGES = 2;
   localparam int DEC_FACTOR = 4;
   localparam int TIMEOUT    = 8;
   localparam int SW         = stage_w(NUM_STAGES);

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic [WIDTH-1:0]  audio_in;
   logic              audio_sample_valid;
   logic              eng_start;
   logic [SW-1:0]     eng_stage;
   logic [WIDTH-1:0]  eng_sample;
   logic              eng_done   = 1'b0;
   logic [WIDTH-1:0]  eng_result = '0;
   logic [WIDTH-1:0]  dec_output;
   logic              dec_output_ready;
   logic              overrun;
   logic              timeout_err;

   fir_stage_scheduler #(
      .WIDTH      (WIDTH),
      .NUM_STAGES (NUM_STAGES),
      .DEC_FACTOR (DEC_FACTOR),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .audio_in           (audio_in),
      .audio_sample_valid (audio_sample_valid),
      .eng_start          (eng_start),
      .eng_stage          (eng_stage),
      .eng_sample         (eng_sample),
      .eng_done           (eng_done),
      .eng_result         (eng_result),
      .dec_output         (dec_output),
      .dec_output_ready   (dec_output_ready),
      .overrun            (overrun),
      .timeout_err        (timeout_err)
   );

   // Free-running 10-unit clock.
   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference model state: expected issues (stage, sample) and outputs.
   int               expStage[$];
   logic [WIDTH-1:0] expSample[$];
   logic [WIDTH-1:0] expDec[$];
   int               modelCnt[NUM_STAGES];

   // One input sample walks down the cascade: every stage it reaches gets an
   // engine issue; only every DEC_FACTOR-th result survives to the next one.
   task automatic modelInput(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] v;
      v = x;
      for (int s = 0; s < NUM_STAGES; s++) begin
         expStage.push_back(s);
         expSample.push_back(v);
         if (modelCnt[s] != DEC_FACTOR - 1) begin
            modelCnt[s]++;
            break;
         end
         modelCnt[s] = 0;
         v = v + 1'b1;
         if (s == NUM_STAGES - 1) expDec.push_back(v);
      end
   endtask

   task automatic modelReset();
      expStage.delete();
      expSample.delete();
      expDec.delete();
      for (int s = 0; s < NUM_STAGES; s++) modelCnt[s] = 0;
   endtask

   // Behavioural FIR engine: result = sample + 1 after engLat cycles.
   int               engLat  = 3;
   bit               engMute = 1'b0;
   bit               engBusy = 1'b0;
   int               engLeft = 0;
   logic [WIDTH-1:0] engRes  = '0;

   always @(negedge clk_in) begin
      eng_done = 1'b0;
      if (engBusy) begin
         if (engLeft <= 1) begin
            eng_done   = 1'b1;
            eng_result = engRes;
            engBusy    = 1'b0;
         end else begin
            engLeft--;
         end
      end
      if (eng_start && !rst_in) begin
         engRes  = eng_sample + 1'b1;
         engLeft = engLat;
         engBusy = !engMute;
      end
   end

   // Monitor: every issue and every final output must match the model.
   int issueCount[NUM_STAGES];
   int readyCount = 0;
   int startLog[$];

   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (eng_start) begin
            issueCount[eng_stage]++;
            startLog.push_back(int'(eng_stage));
            checkOutput("issue_expected", expStage.size() != 0, 1);
            if (expStage.size() != 0) begin
               checkOutput("issue_stage", eng_stage, expStage.pop_front());
               checkOutput("issue_sample", eng_sample, expSample.pop_front());
            end
         end
         if (dec_output_ready) begin
            readyCount++;
            checkOutput("dec_expected", expDec.size() != 0, 1);
            if (expDec.size() != 0) begin
               checkOutput("dec_output", dec_output, expDec.pop_front());
            end
         end
      end
   end

   task automatic applyStimulus(input logic [WIDTH-1:0] x);
      @(negedge clk_in);
      audio_in           = x;
      audio_sample_valid = 1'b1;
      @(negedge clk_in);
      audio_sample_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Bounded wait for the next eng_start; returns on that cycle's negedge.
   task automatic waitStart();
      int n;
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (!eng_start && n < 50);
      if (!eng_start) checkOutput("start_wait", eng_start, 1);
   endtask

   task automatic checkDrained(input string tag);
      checkOutput(tag, expStage.size() + expDec.size(), 0);
   endtask

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] simulation stalled");
   end

   initial begin
      int r0, s0, i1, idx;
      logic [WIDTH-1:0] x;

      rst_in             = 1'b1;
      audio_in           = '0;
      audio_sample_valid = 1'b0;
      idleCycles(3);
      $display("[TB] reset state");
      checkOutput("rst_eng_start", eng_start, 0);
      checkOutput("rst_dec_ready", dec_output_ready, 0);
      checkOutput("rst_overrun", overrun, 0);
      checkOutput("rst_timeout_err", timeout_err, 0);
      rst_in = 1'b0;

      // Inputs 1..16, one every 20 cycles.
      $display("[TB] cascade 1..16");
      r0 = readyCount;
      for (int i = 1; i <= 16; i++) begin
         modelInput(WIDTH'(i));
         applyStimulus(WIDTH'(i));
         idleCycles(18);
      end
      idleCycles(20);
      checkOutput("cascade_stage1_issues", issueCount[1], 4);
      checkOutput("cascade_ready_count", readyCount - r0, 1);
      checkOutput("cascade_dec_output", dec_output, 18);
      checkOutput("cascade_overrun", overrun, 0);
      checkDrained("cascade_drained");

      // Third sample arrives while stage 0 is still pending: dropped.
      $display("[TB] overrun");
      engLat = 6;
      modelInput(8'h21);
      applyStimulus(8'h21);
      waitStart();
      modelInput(8'h22);
      applyStimulus(8'h22);
      applyStimulus(8'h23);
      idleCycles(1);
      checkOutput("overrun_set", overrun, 1);
      idleCycles(40);
      checkOutput("overrun_sticky", overrun, 1);
      checkDrained("overrun_drained");
      engLat = 3;

      // Asynchronous reset between clock edges.
      $display("[TB] mid-cycle reset");
      @(posedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      checkOutput("async_eng_start", eng_start, 0);
      checkOutput("async_eng_stage", eng_stage, 0);
      checkOutput("async_eng_sample", eng_sample, 0);
      checkOutput("async_dec_output", dec_output, 0);
      checkOutput("async_dec_ready", dec_output_ready, 0);
      checkOutput("async_overrun", overrun, 0);
      checkOutput("async_timeout_err", timeout_err, 0);
      modelReset();
      idleCycles(2);
      rst_in = 1'b0;

      // Stage 0 refilled in its own ISSUE cycle, then stage 1 becomes
      // pending alongside it: stage 1 must be issued first.
      $display("[TB] priority and same-cycle refill");
      for (int i = 0; i < 3; i++) begin
         modelInput(WIDTH'(8'h30 + i));
         applyStimulus(WIDTH'(8'h30 + i));
         idleCycles(18);
      end
      idx = startLog.size();
      modelInput(8'h40);
      applyStimulus(8'h40);
      waitStart();
      modelInput(8'h50);
      audio_in           = 8'h50;
      audio_sample_valid = 1'b1;
      @(negedge clk_in);
      audio_sample_valid = 1'b0;
      idleCycles(30);
      checkOutput("prio_start_count", startLog.size() - idx, 3);
      if (startLog.size() - idx == 3) begin
         checkOutput("prio_first", startLog[idx], 0);
         checkOutput("prio_deep_first", startLog[idx + 1], 1);
         checkOutput("prio_shallow_next", startLog[idx + 2], 0);
      end
      checkOutput("prio_overrun", overrun, 0);
      checkDrained("prio_drained");

      // Reset while the engine is busy; its late done must be ignored.
      $display("[TB] reset during WAIT");
      modelInput(8'h60);
      applyStimulus(8'h60);
      waitStart();
      @(negedge clk_in);
      rst_in = 1'b1;
      modelReset();
      idleCycles(2);
      rst_in = 1'b0;
      r0 = readyCount;
      s0 = startLog.size();
      idleCycles(15);
      checkOutput("wrst_no_start", startLog.size() - s0, 0);
      checkOutput("wrst_no_ready", readyCount - r0, 0);
      i1 = issueCount[1];
      for (int i = 0; i < 4; i++) begin
         modelInput(WIDTH'(8'h70 + i));
         applyStimulus(WIDTH'(8'h70 + i));
         idleCycles(18);
      end
      idleCycles(10);
      checkOutput("wrst_restart_stage1", issueCount[1] - i1, 1);
      checkDrained("wrst_drained");

      // Random samples, spacing and engine latency against the model.
      $display("[TB] random traffic");
      for (int i = 0; i < 48; i++) begin
         x      = WIDTH'($urandom);
         engLat = int'($urandom_range(1, 5));
         modelInput(x);
         applyStimulus(x);
         idleCycles(int'($urandom_range(22, 32)));
      end
      idleCycles(30);
      checkOutput("rand_overrun", overrun, 0);
      checkDrained("rand_drained");
      engLat = 3;

`ifdef FIR_SCHED_TIMEOUT_EN
      // Engine never answers: watchdog fires after TIMEOUT WAIT cycles.
      $display("[TB] watchdog");
      engMute = 1'b1;
      expStage.push_back(0);
      expSample.push_back(8'h5A);
      applyStimulus(8'h5A);
      waitStart();
      idleCycles(TIMEOUT);
      checkOutput("timeout_not_early", timeout_err, 0);
      idleCycles(1);
      checkOutput("timeout_err_set", timeout_err, 1);
      engMute = 1'b0;
      s0 = startLog.size();
      modelInput(8'h5B);
      applyStimulus(8'h5B);
      idleCycles(20);
      checkOutput("timeout_reissue", startLog.size() - s0, 1);
      checkOutput("timeout_err_sticky", timeout_err, 1);
      checkDrained("timeout_drained");
`else
      checkOutput("timeout_tied_low", timeout_err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
